// File: rtl/lut4_chain_loader.sv
// rtl/lut4_chain_loader.sv - serialises per-tile config words onto a lut4 ccff chain with tail readback
// Words go out MSB-first; the first word accepted ends up in the tile farthest from ccff_head.

module lut4_chain_loader #(
  parameter int N_TILES = 4,
  parameter int CFG_W   = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             ccff_head,
  output logic             chain_shift,
  input  logic             ccff_tail,
  output logic [CFG_W-1:0] rb_data,
  output logic             rb_valid,
  output logic             busy,
  output logic             done,
  output logic             cfg_loaded
);

  localparam int BW = $clog2(CFG_W);
  localparam int WW = (N_TILES > 1) ? $clog2(N_TILES) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CFG_W-1:0] sreg, sreg_nxt;
  logic [CFG_W-2:0] rb_sreg;
  logic [BW-1:0]    bit_cnt;
  logic [WW-1:0]    word_cnt;
  logic             last_bit;
  logic             last_word;

  assign last_bit  = (bit_cnt == '0);
  assign last_word = (word_cnt == WW'(N_TILES - 1));

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cfg_ready = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = WAIT_WORD;
      end
      WAIT_WORD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          state_nxt = SHIFT;
          sreg_nxt  = cfg_data;
        end
      end
      SHIFT: begin
        sreg_nxt = {sreg[CFG_W-2:0], 1'b0};
        if (last_bit) state_nxt = last_word ? DONE : WAIT_WORD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort freezes the word register; the chain keeps whatever was already shifted in.
    if (abort) begin
      state_nxt = IDLE;
      sreg_nxt  = sreg;
    end
  end

  // chain_shift gates prog_clk, so it and ccff_head come straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sreg        <= '0;
      chain_shift <= 1'b0;
      ccff_head   <= 1'b0;
    end else begin
      state       <= state_nxt;
      sreg        <= sreg_nxt;
      chain_shift <= (state_nxt == SHIFT);
      ccff_head   <= (state_nxt == SHIFT) & sreg_nxt[CFG_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      word_cnt   <= '0;
      rb_sreg    <= '0;
      rb_data    <= '0;
      rb_valid   <= 1'b0;
      cfg_loaded <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (abort) begin
        cfg_loaded <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              word_cnt   <= '0;
              cfg_loaded <= 1'b0;
            end
          end
          WAIT_WORD: begin
            if (cfg_valid) bit_cnt <= BW'(CFG_W - 1);
          end
          SHIFT: begin
            rb_sreg <= {rb_sreg[CFG_W-3:0], ccff_tail};
            if (last_bit) begin
              rb_data  <= {rb_sreg, ccff_tail};
              rb_valid <= 1'b1;
              if (!last_word) word_cnt <= word_cnt + 1'b1;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          DONE: begin
            cfg_loaded <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lut4_chain_loader.sv
// tb/tb_lut4_chain_loader.sv - self-checking bench for lut4_chain_loader
// A 72-bit behavioural chain sits on ccff_head/ccff_tail; loads are compared against word concatenation.

module tb_lut4_chain_loader;

  localparam int N  = 4;
  localparam int W  = 18;
  localparam int CW = N * W;

  typedef struct {
    logic [3:0][W-1:0] w;
    logic [3:0][3:0]   gap;
    logic [CW-1:0]     preload;
    bit                poke;
    int                exp_cyc;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_data = '0;
  logic         cfg_ready, ccff_head, chain_shift, ccff_tail;
  logic [W-1:0] rb_data;
  logic         rb_valid, busy, done, cfg_loaded;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  lut4_chain_loader #(.N_TILES(N), .CFG_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .chain_shift(chain_shift), .ccff_tail(ccff_tail),
    .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .done(done),
    .cfg_loaded(cfg_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [CW-1:0] chain;
  logic [CW-1:0] preload_val = '0;
  logic          preload_req = 1'b0;

  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (chain_shift) chain <= {chain[CW-2:0], ccff_head};
  end
  assign ccff_tail = chain[CW-1];

  bit           got_bits[$];
  logic [W-1:0] got_rb[$];
  int           shift_cnt = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;

  always @(negedge clk) begin
    if (chain_shift) begin
      got_bits.push_back(ccff_head);
      shift_cnt++;
    end
    if (rb_valid) got_rb.push_back(rb_data);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  vec_t tv[10];

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                              input logic [W-1:0] d, input int g2, input logic [CW-1:0] pre,
                              input bit poke, input int exp_cyc);
    vec_t v;
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
    v.gap = '0;
    v.gap[2] = 4'(g2);
    v.preload = pre;
    v.poke = poke;
    v.exp_cyc = exp_cyc;
    return v;
  endfunction

  task automatic set_chain(input logic [CW-1:0] val);
    @(posedge clk); #1;
    preload_val = val;
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
  endtask

  task automatic pulse_start(output int st);
    start = 1'b1;
    st = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap, input bit poke);
    int t = 0;
    while (!cfg_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_wait", CW'(cfg_ready), CW'(1));
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      check("gap_chain_shift", CW'(chain_shift), CW'(0));
      check("gap_cfg_ready", CW'(cfg_ready), CW'(1));
    end
    cfg_valid = 1'b1;
    cfg_data = w;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_data = W'($urandom);
    if (poke) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic run_load(input vec_t v, input int idx);
    int b_bits, b_rb, b_sh, b_done, st, t;
    logic [CW-1:0] eb, gb;
    set_chain(v.preload);
    b_bits = got_bits.size();
    b_rb = got_rb.size();
    b_sh = shift_cnt;
    b_done = done_cnt;
    pulse_start(st);
    for (int i = 0; i < N; i++) send_word(v.w[i], int'(v.gap[i]), v.poke && (i == 1));
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!done && t < 300);
    check($sformatf("v%0d_done_seen", idx), CW'(done), CW'(1));
    if (v.poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("v%0d_busy_after", idx), CW'(busy), CW'(0));
    check($sformatf("v%0d_cfg_loaded", idx), CW'(cfg_loaded), CW'(1));
    check($sformatf("v%0d_done_pulses", idx), CW'(done_cnt - b_done), CW'(1));
    check($sformatf("v%0d_done_latency", idx), CW'(done_cyc - st), CW'(v.exp_cyc));
    check($sformatf("v%0d_shift_cycles", idx), CW'(shift_cnt - b_sh), CW'(CW));
    eb = {v.w[0], v.w[1], v.w[2], v.w[3]};
    gb = '0;
    for (int k = 0; k < CW; k++)
      if (b_bits + k < got_bits.size()) gb[CW-1-k] = got_bits[b_bits + k];
    check($sformatf("v%0d_head_stream", idx), gb, eb);
    check($sformatf("v%0d_chain_image", idx), chain, eb);
    check($sformatf("v%0d_rb_pulses", idx), CW'(got_rb.size() - b_rb), CW'(N));
    for (int i = 0; i < N; i++)
      if (b_rb + i < got_rb.size())
        check($sformatf("v%0d_rb_word%0d", idx, i), CW'(got_rb[b_rb + i]),
              CW'(v.preload[CW-1-W*i -: W]));
  endtask

  initial begin
    int st, b_sh, b_done, b_rb, sum;
    vec_t v;

    tv[0] = mk(18'h2AAAA, 18'h3FFFF, 18'h00001, 18'h15555, 0, '0, 1'b0, 77);
    tv[1] = mk(18'h2AAAA, 18'h3FFFF, 18'h00001, 18'h15555, 10, '0, 1'b0, 87);
    tv[2] = mk(18'h2AAAA, 18'h3FFFF, 18'h00001, 18'h15555, 0, {4{18'h12345}}, 1'b0, 77);
    tv[3] = mk(18'h00000, 18'h3FFFF, 18'h20000, 18'h00001, 0, 72'hF0F0_1234_5678_9ABC_DE, 1'b1, 77);
    for (int r = 4; r < 10; r++) begin
      v.preload = CW'({$urandom, $urandom, $urandom});
      sum = 0;
      for (int i = 0; i < N; i++) begin
        v.w[i] = W'($urandom);
        v.gap[i] = 4'($urandom_range(0, 3));
        sum += int'(v.gap[i]);
      end
      v.poke = 1'b0;
      v.exp_cyc = 77 + sum;
      tv[r] = v;
    end

    preload_val = '0;
    preload_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    preload_req = 1'b0;
    check("reset_outputs", CW'({ccff_head, chain_shift, cfg_ready, rb_data, rb_valid, busy, done, cfg_loaded}), '0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", CW'(busy), CW'(0));
    check("post_reset_ready", CW'(cfg_ready), CW'(0));

    for (int r = 0; r < 10; r++) run_load(tv[r], r);

    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", CW'(busy), CW'(0));
    check("start_abort_ready", CW'(cfg_ready), CW'(0));
    @(posedge clk); #1;
    check("start_abort_busy2", CW'(busy), CW'(0));

    set_chain('0);
    b_sh = shift_cnt;
    b_done = done_cnt;
    b_rb = got_rb.size();
    pulse_start(st);
    send_word(18'h2AAAA, 0, 1'b0);
    send_word(18'h3FFFF, 0, 1'b0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("abort_pre_shift", CW'(chain_shift), CW'(1));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", CW'(busy), CW'(0));
    check("abort_chain_shift", CW'(chain_shift), CW'(0));
    check("abort_ready", CW'(cfg_ready), CW'(0));
    check("abort_cfg_loaded", CW'(cfg_loaded), CW'(0));
    check("abort_shift_count", CW'(shift_cnt - b_sh), CW'(W + 9));
    check("abort_rb_pulses", CW'(got_rb.size() - b_rb), CW'(1));
    repeat (100) @(posedge clk);
    #1;
    check("abort_no_done", CW'(done_cnt - b_done), CW'(0));
    check("abort_idle", CW'(busy), CW'(0));
    run_load(tv[0], 10);

    set_chain('0);
    b_done = done_cnt;
    pulse_start(st);
    send_word(18'h3FFFF, 0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rst_pre_shift", CW'({chain_shift, ccff_head}), CW'(2'b11));
    rst = 1'b0;
    #1;
    check("rst_mid_outputs", CW'({ccff_head, chain_shift, cfg_ready, rb_data, rb_valid, busy, done, cfg_loaded}), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_release_busy", CW'(busy), CW'(0));
    check("rst_release_ready", CW'(cfg_ready), CW'(0));
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_done", CW'(done_cnt - b_done), CW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
